clock_switch_sequencer: RTL and testbench
=========================================

CLOCK_SWITCH_SEQUENCER -- requirements
Module: clock_switch_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, cycles held after a selection change before completion is reported.
REQ-002 SHALL have parameter DWELL_CYCLES, default 64, minimum cycles between a completed switch and the next accepted request.
REQ-003 SHALL have parameter HB_TIMEOUT, default 256, cycles without a heartbeat edge before a clock is declared lost.
REQ-004 SHALL have port aclk, input, 1, the single free-running sequencer clock.
REQ-005 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-006 SHALL have port sw_req, input, 1, switch request valid.
REQ-007 SHALL have port sw_target, input, 1, requested source: 0 = aclk_in1, 1 = aclk_in2.
REQ-008 SHALL have port sw_ready, output, 1, high when a request can be accepted.
REQ-009 SHALL have port sw_done, output, 1, one-cycle pulse on successful completion.
REQ-010 SHALL have port sw_err, output, 1, one-cycle pulse when a request is rejected.
REQ-011 SHALL have port selection, output, 1, registered select driven to the glitchless clock mux.
REQ-012 SHALL have ports hb_in1 and hb_in2, input, 1 each, asynchronous toggle heartbeats from each source domain.
REQ-013 SHALL have ports clk1_lost and clk2_lost, output, 1 each, registered loss flags.
REQ-014 SHALL have port failover, output, 1, one-cycle pulse on an automatic switch.

Function
REQ-015 SHALL implement states IDLE, CHECK, SWITCH, SETTLE, DWELL; sw_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on the cycle sw_req && sw_ready and latch sw_target.
REQ-017 SHALL, if the latched target equals selection, pulse sw_done on the next cycle and remain in IDLE.
REQ-018 SHALL otherwise enter CHECK: if the target's lost flag is 1, pulse sw_err and return to IDLE; otherwise go to SWITCH.
REQ-019 SHALL, in SWITCH, load selection with the target; this is the only state that changes selection.
REQ-020 SHALL count SETTLE_CYCLES in SETTLE, pulse sw_done on the last count, then enter DWELL.
REQ-021 SHALL count DWELL_CYCLES in DWELL, then return to IDLE, ignoring sw_req throughout.
REQ-022 SHALL give a request-accept-to-sw_done latency of exactly SETTLE_CYCLES+2 cycles for a real switch.
REQ-023 SHALL synchronize each heartbeat through 2 flops, detect either edge, and clear a per-source counter on each edge.
REQ-024 SHALL set a lost flag when its counter reaches HB_TIMEOUT, saturate the counter, and clear the flag on the next detected edge.
REQ-025 SHALL size counters with $clog2 of the largest relevant parameter plus 1, with no wrap-around.
REQ-026 SHALL give a heartbeat edge priority over counter increment in the same cycle.

Reset
REQ-027 SHALL, with aresetn low at a rising aclk edge, set state IDLE, selection 0, all counters 0, lost flags 0, and sw_done/sw_err/failover 0.
REQ-028 SHALL abort any in-progress switch on reset, with no sw_done issued for it.

Configuration
REQ-029 SHALL compile auto-failover only when CLKSW_AUTO_FAILOVER_EN is defined: in IDLE, if the selected source is lost and the other is not, switch as if requested, with failover pulsing in the SWITCH cycle.
REQ-030 SHALL, with CLKSW_AUTO_FAILOVER_EN undefined, tie failover to 0 and never change selection without an accepted request.
REQ-031 SHALL give an external sw_req priority over failover on a simultaneous IDLE cycle.

Structure
REQ-032 SHALL place the state encoding and the SEL_CLK1=0/SEL_CLK2=1 constants in package clock_switch_pkg.
REQ-033 SHALL implement the heartbeat synchronizer and timeout counter as sub-module heartbeat_monitor, instantiated twice.

Verification
REQ-034 SHALL cover a basic switch: both heartbeats toggling every 4 cycles, SETTLE=16, request target=1 -> selection=1 one cycle after CHECK, sw_done exactly 18 cycles after accept, sw_ready low for 18+64 cycles.
REQ-035 SHALL cover a same-target request: target=0 while selection=0 -> sw_done the next cycle, selection unchanged, sw_ready stays 1.
REQ-036 SHALL cover a lost target: hb_in2 held constant for 300 cycles -> clk2_lost=1 at the 256-cycle timeout, request target=1 -> sw_err pulse, selection remains 0.
REQ-037 SHALL cover reset mid-SETTLE: aresetn low at settle count 5 -> selection=0, state IDLE, no sw_done.
REQ-038 SHALL cover failover with CLKSW_AUTO_FAILOVER_EN defined: selection=0 and hb_in1 stopped -> after 256 cycles clk1_lost=1, failover pulse, selection=1; the same stimulus with the macro undefined -> selection stays 0.
REQ-039 SHALL cover loss recovery: a single edge on a lost heartbeat -> lost flag cleared within 3 cycles.

Source files
------------

// File: rtl/clock_switch_pkg.sv
// Shared definitions for the clock switch sequencer: FSM encoding, source
// select constants and the counter sizing helper.
package clock_switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SWITCH,
        ST_SETTLE,
        ST_DWELL
    } sw_state_e;

    localparam logic SEL_CLK1 = 1'b0;
    localparam logic SEL_CLK2 = 1'b1;

    // One spare bit so a counter can hold max_count itself without wrapping.
    function automatic int unsigned counter_width(input int unsigned max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/heartbeat_monitor.sv
// Heartbeat watchdog for one source: two-flop synchronizer, either-edge
// detector and a saturating timeout counter that raises a registered lost flag.
module heartbeat_monitor #(
    parameter int unsigned HB_TIMEOUT = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic hb_in,
    output logic lost
);
    import clock_switch_pkg::*;

    localparam int unsigned CNT_W = counter_width(HB_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HB_TIMEOUT);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic             hb_edge;

    // An edge always wins over the increment, so a live source can never
    // be flagged in the same cycle it shows activity.
    always_comb begin
        sync1_d = hb_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        hb_edge = sync2_q ^ prev_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        if (hb_edge) begin
            cnt_d  = '0;
            lost_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            lost_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    assign lost = lost_q;

endmodule

// File: rtl/clock_switch_sequencer.sv
// Sequencer driving a glitchless clock mux select with settle/dwell timing and
// heartbeat loss detection. Define CLKSW_AUTO_FAILOVER_EN to enable auto-failover.
module clock_switch_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 64,
    parameter int unsigned HB_TIMEOUT    = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic sw_req,
    input  logic sw_target,
    output logic sw_ready,
    output logic sw_done,
    output logic sw_err,
    output logic selection,
    input  logic hb_in1,
    input  logic hb_in2,
    output logic clk1_lost,
    output logic clk2_lost,
    output logic failover
);
    import clock_switch_pkg::*;

    localparam int unsigned SEQ_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int unsigned CNT_W   = counter_width(SEQ_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             auto_q, auto_d;
    logic             selection_q, selection_d;
    logic             sw_done_q, sw_done_d;
    logic             sw_err_q, sw_err_d;
    logic             failover_q, failover_d;
    logic             target_lost;
    logic             auto_start;

    heartbeat_monitor #(
        .HB_TIMEOUT(HB_TIMEOUT)
    ) u_hb1 (
        .aclk   (aclk),
        .aresetn(aresetn),
        .hb_in  (hb_in1),
        .lost   (clk1_lost)
    );

    heartbeat_monitor #(
        .HB_TIMEOUT(HB_TIMEOUT)
    ) u_hb2 (
        .aclk   (aclk),
        .aresetn(aresetn),
        .hb_in  (hb_in2),
        .lost   (clk2_lost)
    );

    // Failover fires only when moving away from a dead source to a live one.
    always_comb begin
        auto_start = 1'b0;
`ifdef CLKSW_AUTO_FAILOVER_EN
        auto_start = (selection_q ? clk2_lost : clk1_lost) &&
                     !(selection_q ? clk1_lost : clk2_lost);
`endif
    end

    assign target_lost = (target_q == SEL_CLK2) ? clk2_lost : clk1_lost;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        auto_d      = auto_q;
        selection_d = selection_q;
        sw_done_d   = 1'b0;
        sw_err_d    = 1'b0;
        failover_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sw_req) begin
                    target_d = sw_target;
                    auto_d   = 1'b0;
                    if (sw_target == selection_q) begin
                        sw_done_d = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (auto_start) begin
                    target_d = ~selection_q;
                    auto_d   = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (target_lost) begin
                    sw_err_d = ~auto_q;
                    state_d  = ST_IDLE;
                end else begin
                    failover_d = auto_q;
                    state_d    = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                selection_d = target_q;
                cnt_d       = '0;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DWELL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered pulse lines up with the final settle cycle.
        if (state_d == ST_SETTLE && cnt_d == SETTLE_LAST) begin
            sw_done_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            target_q    <= SEL_CLK1;
            auto_q      <= 1'b0;
            selection_q <= SEL_CLK1;
            sw_done_q   <= 1'b0;
            sw_err_q    <= 1'b0;
            failover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            auto_q      <= auto_d;
            selection_q <= selection_d;
            sw_done_q   <= sw_done_d;
            sw_err_q    <= sw_err_d;
            failover_q  <= failover_d;
        end
    end

    assign sw_ready  = (state_q == ST_IDLE);
    assign sw_done   = sw_done_q;
    assign sw_err    = sw_err_q;
    assign selection = selection_q;
    assign failover  = failover_q;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench for clock_switch_sequencer: switch timing, rejection, reset
// abort, heartbeat loss/recovery and failover (macro-dependent expectations).
module tb_clock_switch_sequencer;

    logic aclk      = 1'b0;
    logic aresetn   = 1'b0;
    logic sw_req    = 1'b0;
    logic sw_target = 1'b0;
    logic hb_in1    = 1'b0;
    logic hb_in2    = 1'b0;
    logic sw_ready, sw_done, sw_err, selection;
    logic clk1_lost, clk2_lost, failover;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit hb1_run     = 1'b1;
    bit hb2_run     = 1'b1;
    int hb1_last    = 0;
    int hb2_last    = 0;

    clock_switch_sequencer dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .sw_req   (sw_req),
        .sw_target(sw_target),
        .sw_ready (sw_ready),
        .sw_done  (sw_done),
        .sw_err   (sw_err),
        .selection(selection),
        .hb_in1   (hb_in1),
        .hb_in2   (hb_in2),
        .clk1_lost(clk1_lost),
        .clk2_lost(clk2_lost),
        .failover (failover)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Heartbeats toggle every 4 cycles on the falling edge; the cycle of the
    // last toggle anchors the exact timeout expectations.
    initial begin
        forever begin
            repeat (4) @(negedge aclk);
            if (hb1_run) begin
                hb_in1   = ~hb_in1;
                hb1_last = cyc;
            end
            if (hb2_run) begin
                hb_in2   = ~hb_in2;
                hb2_last = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Presents a request for one cycle; returns in the first cycle after acceptance.
    task automatic applyStimulus(input logic target);
        sw_req    = 1'b1;
        sw_target = target;
        @(negedge aclk);
        sw_req    = 1'b0;
    endtask

    task automatic applyReset();
        aresetn = 1'b0;
        waitCycles(3);
        aresetn = 1'b1;
        waitCycles(2);
    endtask

    // Stops at the last cycle before the lost flag is due (258 cycles after the
    // final toggle: 3 cycles of sync/edge detection, then 255 counts).
    task automatic waitForLoss(input int which, output bit ok);
        int last;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            last = (which == 1) ? hb1_last : hb2_last;
            if (cyc == last + 258) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
    endtask

    initial begin
        int done_at, done_cnt, ready_back, sel2, sel3, fo_cnt;
        bit ok;

        // Reset state
        aresetn = 1'b0;
        waitCycles(3);
        checkOutput("rst_ready", sw_ready, 1);
        checkOutput("rst_selection", selection, 0);
        checkOutput("rst_done", sw_done, 0);
        checkOutput("rst_err", sw_err, 0);
        checkOutput("rst_failover", failover, 0);
        checkOutput("rst_clk1_lost", clk1_lost, 0);
        checkOutput("rst_clk2_lost", clk2_lost, 0);
        aresetn = 1'b1;
        waitCycles(10);

        // Same-target request completes immediately
        applyStimulus(1'b0);
        checkOutput("same_done", sw_done, 1);
        checkOutput("same_selection", selection, 0);
        checkOutput("same_ready", sw_ready, 1);
        waitCycles(1);
        checkOutput("same_done_width", sw_done, 0);
        waitCycles(5);

        // Basic switch to source 2
        done_at = 0; done_cnt = 0; ready_back = 0; sel2 = -1; sel3 = -1;
        applyStimulus(1'b1);
        for (int k = 1; k <= 120; k++) begin
            if (sw_done) begin
                done_cnt++;
                done_at = k;
            end
            if (sw_ready && ready_back == 0) ready_back = k;
            if (k == 2) sel2 = selection;
            if (k == 3) sel3 = selection;
            @(negedge aclk);
        end
        checkOutput("sw_done_latency", done_at, 18);
        checkOutput("sw_done_pulses", done_cnt, 1);
        checkOutput("ready_returns_cycle", ready_back, 83);
        checkOutput("sel_in_switch", sel2, 0);
        checkOutput("sel_after_switch", sel3, 1);
        checkOutput("sel_final", selection, 1);

        // Reset during settle aborts the switch
        applyReset();
        applyStimulus(1'b1);
        waitCycles(7);
        checkOutput("abort_sel_before", selection, 1);
        checkOutput("abort_ready_before", sw_ready, 0);
        aresetn = 1'b0;
        waitCycles(1);
        checkOutput("abort_selection", selection, 0);
        checkOutput("abort_ready", sw_ready, 1);
        aresetn = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (sw_done) done_cnt++;
            @(negedge aclk);
        end
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_sel_after", selection, 0);

        // Lost target is rejected
        hb2_run = 1'b0;
        waitForLoss(2, ok);
        checkOutput("hb2_wait_bound", ok, 1);
        checkOutput("clk2_lost_before_timeout", clk2_lost, 0);
        waitCycles(1);
        checkOutput("clk2_lost_at_timeout", clk2_lost, 1);
        checkOutput("clk1_still_alive", clk1_lost, 0);
        waitCycles(20);
        checkOutput("clk2_lost_held", clk2_lost, 1);
        applyStimulus(1'b1);
        checkOutput("err_cycle1", sw_err, 0);
        waitCycles(1);
        checkOutput("err_pulse", sw_err, 1);
        checkOutput("err_ready", sw_ready, 1);
        waitCycles(1);
        checkOutput("err_width", sw_err, 0);
        checkOutput("err_selection", selection, 0);
        checkOutput("err_no_done", sw_done, 0);

        // Single heartbeat edge clears the loss
        hb_in2 = ~hb_in2;
        checkOutput("clk2_lost_pre_recover", clk2_lost, 1);
        waitCycles(3);
        checkOutput("clk2_recovered", clk2_lost, 0);
        hb2_run = 1'b1;
        waitCycles(10);

        // Selected source dies
        hb1_run = 1'b0;
        waitForLoss(1, ok);
        checkOutput("hb1_wait_bound", ok, 1);
        checkOutput("clk1_lost_before_timeout", clk1_lost, 0);
        waitCycles(1);
        checkOutput("clk1_lost_at_timeout", clk1_lost, 1);
        fo_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (failover) fo_cnt++;
            @(negedge aclk);
        end
`ifdef CLKSW_AUTO_FAILOVER_EN
        checkOutput("failover_pulses", fo_cnt, 1);
        checkOutput("failover_selection", selection, 1);
`else
        checkOutput("failover_pulses", fo_cnt, 0);
        checkOutput("failover_selection", selection, 0);
`endif

        hb_in1 = ~hb_in1;
        waitCycles(3);
        checkOutput("clk1_recovered", clk1_lost, 0);
        hb1_run = 1'b1;
        waitCycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
